lcd_bus_monitor: RTL and testbench
==================================

Name: lcd_bus_monitor

Overview:
- Receiving end of the HD44780-style 8-bit parallel LCD bus (rs/en/rw/dat) that the vending-machine display driver produces.
- Latches each bus transfer on the falling edge of en, decodes the instruction set, and maintains a 16-character line buffer mirroring the panel's first line.
- Used as an on-chip display-echo (debug/self-check) and as the bench's LCD model for the driver.

Parameters:
- BUSY_CYCLES, 2000, clk cycles busy after any data write or non-clear/home command.
- CLR_BUSY_CYCLES, 60000, clk cycles busy after clear (0x01) or home (0x02/0x03).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rs  in  1  register select: 0 = instruction, 1 = data
- en  in  1  enable strobe; transfer latched on its falling edge
- rw  in  1  0 = write, 1 = read
- dat  in  8  bus data
- rd_addr  in  4  line-buffer read address
- rd_data  out  8  buffer[rd_addr], registered, 1-cycle latency
- err_clr  in  1  clears all sticky error flags
- char_wr  out  1  1-cycle pulse when a character is stored
- char_addr  out  4  position of the stored character
- char_dat  out  8  stored character
- line_done  out  1  1-cycle pulse, coincident with char_wr, when position 15 is written
- ddram_addr  out  7  current address counter
- disp_on, cursor_on, blink_on  out  1 each  display-control state
- inc_mode  out  1  entry mode I/D (1 = increment)
- busy  out  1  emulated busy flag
- err_overrun  out  1  sticky: transfer latched while busy
- err_unsupported  out  1  sticky: CGRAM-address command or out-of-range DDRAM address
- err_read  out  1  sticky: transfer with rw=1

Behaviour:
- Reset values:
  - buffer all 0x20; ddram_addr=0; inc_mode=1; disp_on/cursor_on/blink_on=0.
  - busy, all err_* flags, char_wr, line_done = 0; char_addr=0; char_dat=0x20; rd_data=0x20.
- Input sampling:
  - en, rs, rw and dat pass through 2-flop synchronizers, all aligned.
  - A fall is detected when sync_en goes 1->0 (3rd flop holds the previous value).
  - Fixed latency: effects (char_wr, state updates) register on the 3rd rising clk edge after en is first sampled low.
- Transfer with rw=1: set err_read; no other effect.
- Any latched transfer while busy=1: set err_overrun, then process the transfer normally; busy counter restarts.
- Instructions (rs=0), priority is MSB-first:
  - 1aaa_aaaa set DDRAM address:
    - aaaaaaa <= 0x4F: ddram_addr = aaaaaaa.
    - Otherwise: ddram_addr = 0 and set err_unsupported.
  - 01xx_xxxx CGRAM address: ignored; set err_unsupported.
  - 001x_xxxx function set: accepted, no state change.
  - 0001_SRxx cursor/display shift:
    - S=0: address moves +1 if R=1, -1 if R=0, with wrap.
    - S=1: ignored.
  - 0000_1DCB: disp_on=D, cursor_on=C, blink_on=B.
  - 0000_01IS: inc_mode=I; S ignored.
  - 0000_001x home: ddram_addr=0.
  - 0000_0001 clear: buffer all 0x20, ddram_addr=0, inc_mode=1.
  - 0x00: no-op.
- Data writes (rs=1):
  - If ddram_addr < 16: buffer[ddram_addr] = dat and pulse char_wr with char_addr/char_dat. line_done also pulses when the address is 15.
  - If ddram_addr >= 16: write dropped, no pulse.
  - After the write, ddram_addr moves +1 or -1 per inc_mode.
- Address wrap: 0x4F+1 -> 0x00; 0x00-1 -> 0x4F.
- Busy:
  - Loaded with CLR_BUSY_CYCLES on clear/home, BUSY_CYCLES on any other accepted rw=0 transfer.
  - Counts down each clk; busy = (count != 0).
- err_clr: clears all sticky flags the next cycle. If an error event occurs in the same cycle, the event wins and the flag stays set.
- rd_data reads the buffer value as of the previous cycle. A write and a read to the same address in the same cycle return the old value.
- rst_n low mid-transfer: immediate return to reset values; a pending en edge is discarded.

Test Plan:
- Reset, then the sequence 0x30, 0x0C, 0x06, 0x01, then " WELCOME!" + 7 spaces with rs=1, each en half-period 200 clk, CLR_BUSY_CYCLES=100, BUSY_CYCLES=50 -> buffer reads " WELCOME!       ", disp_on=1, cursor_on=0, 16 char_wr pulses, line_done on the 16th, ddram_addr=0x10, no errors.
- Set address 0x85, write 'X' -> char_wr with char_addr=5, char_dat=0x58; ddram_addr=0x06.
- Entry mode 0x04, set address 0x80, write 'A' -> buffer[0]=0x41 and ddram_addr wraps to 0x4F. A further write produces no char_wr, ddram_addr=0x4E.
- Clear (0x01) followed by a data write 20 clk later (before CLR_BUSY_CYCLES) -> err_overrun=1, write still lands at 0. Pulse err_clr -> err_overrun=0.
- Transfer with rw=1 -> err_read=1, buffer unchanged. Command 0x40 -> err_unsupported=1. Command 0xD5 -> err_unsupported=1, ddram_addr=0.
- Assert rst_n low with en high mid-transfer, release, let en fall -> that first transfer is ignored only if its edge predates release. Buffer is all 0x20 and outputs are at reset values.

Source files
------------

// File: rtl/lcd_bus_monitor.sv
// Receive-side model of an HD44780-style 8-bit LCD bus: latches transfers on the
// falling edge of en, decodes instructions and mirrors the first 16 characters.
module lcd_bus_monitor #(
  parameter int BUSY_CYCLES     = 2000,
  parameter int CLR_BUSY_CYCLES = 60000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rs,
  input  logic       en,
  input  logic       rw,
  input  logic [7:0] dat,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data,
  input  logic       err_clr,
  output logic       char_wr,
  output logic [3:0] char_addr,
  output logic [7:0] char_dat,
  output logic       line_done,
  output logic [6:0] ddram_addr,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       inc_mode,
  output logic       busy,
  output logic       err_overrun,
  output logic       err_unsupported,
  output logic       err_read
);

  localparam int MAX_BUSY = (CLR_BUSY_CYCLES > BUSY_CYCLES) ? CLR_BUSY_CYCLES : BUSY_CYCLES;
  localparam int CW = $clog2(MAX_BUSY + 1);
  localparam logic [CW-1:0] BUSY_LD = CW'(BUSY_CYCLES);
  localparam logic [CW-1:0] CLR_LD  = CW'(CLR_BUSY_CYCLES);
  localparam logic [6:0] ADDR_MAX = 7'h4F;
  localparam logic [7:0] BLANK = 8'h20;

  function automatic logic [6:0] addr_step(input logic [6:0] a, input logic up);
    if (up) return (a == ADDR_MAX) ? 7'h00 : a + 7'd1;
    else    return (a == 7'h00) ? ADDR_MAX : a - 7'd1;
  endfunction

  logic       en_p0, en_p1, en_p2;
  logic       rs_p0, rs_p1, rw_p0, rw_p1;
  logic [7:0] dat_p0, dat_p1;
  logic       vld_p1;
  logic [7:0] line_buf [16];
  logic [CW-1:0] busy_cnt;

  logic [6:0] addr_nxt;
  logic       disp_nxt, cursor_nxt, blink_nxt, inc_nxt;
  logic       wr_en, clr_buf, load_busy, load_long;
  logic       ev_overrun, ev_unsup, ev_read;

  // Stage p0/p1: two-flop synchronizers; en_p2 holds the previous synced en
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_p0  <= 1'b0;  en_p1 <= 1'b0;  en_p2 <= 1'b0;
      rs_p0  <= 1'b0;  rs_p1 <= 1'b0;
      rw_p0  <= 1'b0;  rw_p1 <= 1'b0;
      dat_p0 <= '0;    dat_p1 <= '0;
    end else begin
      en_p0  <= en;    en_p1 <= en_p0;  en_p2 <= en_p1;
      rs_p0  <= rs;    rs_p1 <= rs_p0;
      rw_p0  <= rw;    rw_p1 <= rw_p0;
      dat_p0 <= dat;   dat_p1 <= dat_p0;
    end
  end

  assign vld_p1 = en_p2 & ~en_p1;
  assign busy   = (busy_cnt != '0);

  always_comb begin
    addr_nxt   = ddram_addr;
    disp_nxt   = disp_on;
    cursor_nxt = cursor_on;
    blink_nxt  = blink_on;
    inc_nxt    = inc_mode;
    wr_en      = 1'b0;
    clr_buf    = 1'b0;
    load_busy  = 1'b0;
    load_long  = 1'b0;
    ev_overrun = 1'b0;
    ev_unsup   = 1'b0;
    ev_read    = 1'b0;
    if (vld_p1) begin
      ev_overrun = busy;
      if (rw_p1) begin
        ev_read = 1'b1;
      end else begin
        load_busy = 1'b1;
        if (rs_p1) begin
          wr_en    = (ddram_addr < 7'd16);
          addr_nxt = addr_step(ddram_addr, inc_mode);
        end else if (dat_p1[7]) begin
          if (dat_p1[6:0] <= ADDR_MAX) addr_nxt = dat_p1[6:0];
          else begin
            addr_nxt = 7'h00;
            ev_unsup = 1'b1;
          end
        end else if (dat_p1[6]) begin
          ev_unsup = 1'b1;
        end else if (!dat_p1[5]) begin
          // Function set (001x_xxxx) falls through with no state change
          if (dat_p1[4]) begin
            if (!dat_p1[3]) addr_nxt = addr_step(ddram_addr, dat_p1[2]);
          end else if (dat_p1[3]) begin
            {disp_nxt, cursor_nxt, blink_nxt} = dat_p1[2:0];
          end else if (dat_p1[2]) begin
            inc_nxt = dat_p1[1];
          end else if (dat_p1[1]) begin
            addr_nxt  = 7'h00;
            load_long = 1'b1;
          end else if (dat_p1[0]) begin
            clr_buf   = 1'b1;
            addr_nxt  = 7'h00;
            inc_nxt   = 1'b1;
            load_long = 1'b1;
          end
        end
      end
    end
  end

  // Stage p2: architectural state, buffer and output pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) line_buf[i] <= BLANK;
      ddram_addr      <= 7'h00;
      disp_on         <= 1'b0;
      cursor_on       <= 1'b0;
      blink_on        <= 1'b0;
      inc_mode        <= 1'b1;
      busy_cnt        <= '0;
      err_overrun     <= 1'b0;
      err_unsupported <= 1'b0;
      err_read        <= 1'b0;
      char_wr         <= 1'b0;
      line_done       <= 1'b0;
      char_addr       <= 4'h0;
      char_dat        <= BLANK;
      rd_data         <= BLANK;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (clr_buf) line_buf[i] <= BLANK;
        else if (wr_en && ddram_addr[3:0] == 4'(i)) line_buf[i] <= dat_p1;
      end
      ddram_addr <= addr_nxt;
      disp_on    <= disp_nxt;
      cursor_on  <= cursor_nxt;
      blink_on   <= blink_nxt;
      inc_mode   <= inc_nxt;
      if (load_busy)     busy_cnt <= load_long ? CLR_LD : BUSY_LD;
      else if (busy)     busy_cnt <= busy_cnt - 1'b1;
      err_overrun     <= ev_overrun | (err_overrun & ~err_clr);
      err_unsupported <= ev_unsup   | (err_unsupported & ~err_clr);
      err_read        <= ev_read    | (err_read & ~err_clr);
      char_wr   <= wr_en;
      line_done <= wr_en && (ddram_addr[3:0] == 4'hF);
      if (wr_en) begin
        char_addr <= ddram_addr[3:0];
        char_dat  <= dat_p1;
      end
      rd_data <= line_buf[rd_addr];
    end
  end

endmodule

// File: tb/tb_lcd_bus_monitor.sv
// Directed bench for lcd_bus_monitor: table of bus transfers with expected
// state, plus hand-written sequences for busy, error, latency and reset cases.
module tb_lcd_bus_monitor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rs = 1'b0, en = 1'b0, rw = 1'b0;
  logic [7:0] dat = 8'h00;
  logic [3:0] rd_addr = 4'h0;
  logic [7:0] rd_data;
  logic       err_clr = 1'b0;
  logic       char_wr, line_done;
  logic [3:0] char_addr;
  logic [7:0] char_dat;
  logic [6:0] ddram_addr;
  logic       disp_on, cursor_on, blink_on, inc_mode, busy;
  logic       err_overrun, err_unsupported, err_read;

  lcd_bus_monitor #(.BUSY_CYCLES(50), .CLR_BUSY_CYCLES(100)) dut (
    .clk(clk), .rst_n(rst_n), .rs(rs), .en(en), .rw(rw), .dat(dat),
    .rd_addr(rd_addr), .rd_data(rd_data), .err_clr(err_clr),
    .char_wr(char_wr), .char_addr(char_addr), .char_dat(char_dat),
    .line_done(line_done), .ddram_addr(ddram_addr), .disp_on(disp_on),
    .cursor_on(cursor_on), .blink_on(blink_on), .inc_mode(inc_mode),
    .busy(busy), .err_overrun(err_overrun),
    .err_unsupported(err_unsupported), .err_read(err_read)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int ld_cnt = 0;
  logic [3:0] ld_addr = 4'h0;
  logic [3:0] last_caddr = 4'h0;
  logic [7:0] last_cdat = 8'h00;

  always @(negedge clk) begin
    if (char_wr) begin
      wr_cnt++;
      last_caddr = char_addr;
      last_cdat  = char_dat;
    end
    if (line_done) begin
      ld_cnt++;
      ld_addr = char_addr;
    end
  end

  typedef struct {
    logic       rs;
    logic [7:0] d;
    logic [6:0] exp_addr;
    logic       exp_wr;
    logic [3:0] exp_caddr;
    logic [7:0] exp_cdat;
    logic       exp_inc;
    logic [2:0] exp_dcb;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic xfer(input logic r_s, input logic r_w, input logic [7:0] d, input int half);
    @(posedge clk); #1;
    rs = r_s; rw = r_w; dat = d; en = 1'b1;
    repeat (half) @(posedge clk);
    #1 en = 1'b0;
    repeat (half) @(posedge clk);
    #1;
  endtask

  task automatic read_buf(input logic [3:0] a, output logic [7:0] d);
    @(posedge clk); #1 rd_addr = a;
    @(posedge clk); @(posedge clk); #1 d = rd_data;
  endtask

  task automatic apply(input int i);
    vec_t v;
    int w0;
    v = tbl[i];
    w0 = wr_cnt;
    xfer(v.rs, 1'b0, v.d, 200);
    check($sformatf("v%0d ddram_addr", i), ddram_addr, v.exp_addr);
    check($sformatf("v%0d char_wr count", i), wr_cnt - w0, v.exp_wr);
    if (v.exp_wr) begin
      check($sformatf("v%0d char_addr", i), last_caddr, v.exp_caddr);
      check($sformatf("v%0d char_dat", i), last_cdat, v.exp_cdat);
    end
    check($sformatf("v%0d inc_mode", i), inc_mode, v.exp_inc);
    check($sformatf("v%0d disp/cur/blink", i), {disp_on, cursor_on, blink_on}, v.exp_dcb);
    check($sformatf("v%0d err flags", i), {err_overrun, err_unsupported, err_read}, 3'b000);
  endtask

  task automatic pulse_err_clr();
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    string s;
    logic [7:0] rb;
    int w0;
    s = " WELCOME!       ";

    tbl.push_back('{1'b0, 8'h30, 7'h00, 1'b0, 4'h0, 8'h00, 1'b1, 3'b000});
    tbl.push_back('{1'b0, 8'h0C, 7'h00, 1'b0, 4'h0, 8'h00, 1'b1, 3'b100});
    tbl.push_back('{1'b0, 8'h06, 7'h00, 1'b0, 4'h0, 8'h00, 1'b1, 3'b100});
    tbl.push_back('{1'b0, 8'h01, 7'h00, 1'b0, 4'h0, 8'h00, 1'b1, 3'b100});
    for (int i = 0; i < 16; i++)
      tbl.push_back('{1'b1, s[i], 7'(i + 1), 1'b1, 4'(i), s[i], 1'b1, 3'b100});
    tbl.push_back('{1'b0, 8'h85, 7'h05, 1'b0, 4'h0, 8'h00, 1'b1, 3'b100});
    tbl.push_back('{1'b1, 8'h58, 7'h06, 1'b1, 4'h5, 8'h58, 1'b1, 3'b100});
    tbl.push_back('{1'b0, 8'h04, 7'h06, 1'b0, 4'h0, 8'h00, 1'b0, 3'b100});
    tbl.push_back('{1'b0, 8'h80, 7'h00, 1'b0, 4'h0, 8'h00, 1'b0, 3'b100});
    tbl.push_back('{1'b1, 8'h41, 7'h4F, 1'b1, 4'h0, 8'h41, 1'b0, 3'b100});
    tbl.push_back('{1'b1, 8'h42, 7'h4E, 1'b0, 4'h0, 8'h00, 1'b0, 3'b100});
    tbl.push_back('{1'b0, 8'h14, 7'h4F, 1'b0, 4'h0, 8'h00, 1'b0, 3'b100});
    tbl.push_back('{1'b0, 8'h14, 7'h00, 1'b0, 4'h0, 8'h00, 1'b0, 3'b100});
    tbl.push_back('{1'b0, 8'h10, 7'h4F, 1'b0, 4'h0, 8'h00, 1'b0, 3'b100});
    tbl.push_back('{1'b0, 8'h18, 7'h4F, 1'b0, 4'h0, 8'h00, 1'b0, 3'b100});
    tbl.push_back('{1'b0, 8'h0F, 7'h4F, 1'b0, 4'h0, 8'h00, 1'b0, 3'b111});
    tbl.push_back('{1'b0, 8'h02, 7'h00, 1'b0, 4'h0, 8'h00, 1'b0, 3'b111});
    tbl.push_back('{1'b0, 8'h00, 7'h00, 1'b0, 4'h0, 8'h00, 1'b0, 3'b111});

    // Reset state
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst ddram_addr", ddram_addr, 7'h00);
    check("rst inc_mode", inc_mode, 1'b1);
    check("rst disp/cur/blink", {disp_on, cursor_on, blink_on}, 3'b000);
    check("rst busy", busy, 1'b0);
    check("rst err flags", {err_overrun, err_unsupported, err_read}, 3'b000);
    check("rst char_wr/line_done", {char_wr, line_done}, 2'b00);
    check("rst char_addr", char_addr, 4'h0);
    check("rst char_dat", char_dat, 8'h20);
    check("rst rd_data", rd_data, 8'h20);

    // Init + welcome line
    for (int i = 0; i < 20; i++) apply(i);
    check("welcome char_wr total", wr_cnt, 16);
    check("welcome line_done count", ld_cnt, 1);
    check("welcome line_done addr", ld_addr, 4'hF);
    for (int i = 0; i < 16; i++) begin
      read_buf(4'(i), rb);
      check($sformatf("welcome buf[%0d]", i), rb, s[i]);
    end

    // Addressing, decrement mode, wrap, shifts, display control, home
    for (int i = 20; i < tbl.size(); i++) apply(i);
    read_buf(4'h0, rb); check("buf[0] after A", rb, 8'h41);
    read_buf(4'h5, rb); check("buf[5] after X", rb, 8'h58);
    read_buf(4'h1, rb); check("buf[1] kept", rb, 8'h57);

    // Clear then write 20 clk later while still busy
    w0 = wr_cnt;
    @(posedge clk); #1 rs = 1'b0; rw = 1'b0; dat = 8'h01; en = 1'b1;
    repeat (5) @(posedge clk); #1 en = 1'b0;
    repeat (10) @(posedge clk); #1 rs = 1'b1; dat = 8'h5A; en = 1'b1;
    repeat (10) @(posedge clk); #1 en = 1'b0;
    repeat (10) @(posedge clk); #1;
    check("overrun flag", err_overrun, 1'b1);
    check("overrun write count", wr_cnt - w0, 1);
    check("overrun char_addr", last_caddr, 4'h0);
    check("overrun char_dat", last_cdat, 8'h5A);
    check("overrun ddram_addr", ddram_addr, 7'h01);
    check("clear inc_mode", inc_mode, 1'b1);
    read_buf(4'h0, rb); check("clear buf[0]", rb, 8'h5A);
    read_buf(4'h5, rb); check("clear buf[5]", rb, 8'h20);
    pulse_err_clr();
    #1 check("err_clr overrun", err_overrun, 1'b0);
    repeat (150) @(posedge clk);

    // Read transfer: error only, no busy, no write
    w0 = wr_cnt;
    xfer(1'b1, 1'b1, 8'h55, 20);
    check("read err_read", err_read, 1'b1);
    check("read busy", busy, 1'b0);
    check("read no write", wr_cnt - w0, 0);
    check("read ddram_addr", ddram_addr, 7'h01);
    read_buf(4'h1, rb); check("read buf[1]", rb, 8'h20);
    rw = 1'b0;

    // Unsupported commands and address range
    xfer(1'b0, 1'b0, 8'h40, 100);
    check("cgram err_unsupported", err_unsupported, 1'b1);
    check("cgram ddram_addr", ddram_addr, 7'h01);
    pulse_err_clr();
    #1 check("err_clr all", {err_overrun, err_unsupported, err_read}, 3'b000);
    xfer(1'b0, 1'b0, 8'hCF, 100);
    check("addr 0x4F ddram_addr", ddram_addr, 7'h4F);
    check("addr 0x4F no error", err_unsupported, 1'b0);
    xfer(1'b0, 1'b0, 8'hD5, 100);
    check("addr 0x55 err_unsupported", err_unsupported, 1'b1);
    check("addr 0x55 ddram_addr", ddram_addr, 7'h00);

    // Fixed three-edge latency from en sampled low to char_wr
    @(posedge clk); #1 rs = 1'b1; dat = 8'h51; en = 1'b1;
    repeat (5) @(posedge clk); #1 en = 1'b0;
    @(posedge clk); #1 check("latency edge1", char_wr, 1'b0);
    @(posedge clk); #1 check("latency edge2", char_wr, 1'b0);
    @(posedge clk); #1 check("latency edge3 char_wr", char_wr, 1'b1);
    check("latency char_addr", char_addr, 4'h0);
    check("latency char_dat", char_dat, 8'h51);
    check("latency line_done", line_done, 1'b0);
    @(posedge clk); #1 check("char_wr one cycle", char_wr, 1'b0);
    repeat (10) @(posedge clk);

    // Reset with en edge during reset: discarded
    @(posedge clk); #1 rs = 1'b0; dat = 8'h0F; en = 1'b1;
    repeat (5) @(posedge clk); #1 rst_n = 1'b0;
    repeat (3) @(posedge clk); #1 en = 1'b0;
    repeat (3) @(posedge clk); #1 rst_n = 1'b1;
    repeat (10) @(posedge clk); #1;
    check("rst-edge disp/cur/blink", {disp_on, cursor_on, blink_on}, 3'b000);
    check("rst-edge ddram_addr", ddram_addr, 7'h00);
    check("rst-edge err flags", {err_overrun, err_unsupported, err_read}, 3'b000);
    check("rst-edge busy", busy, 1'b0);
    check("rst-edge char_dat", char_dat, 8'h20);

    // Reset with en still high at release: the later fall is processed
    en = 1'b1;
    repeat (5) @(posedge clk); #1 rst_n = 1'b0;
    repeat (3) @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(posedge clk); #1 en = 1'b0;
    repeat (10) @(posedge clk); #1;
    check("post-rst disp/cur/blink", {disp_on, cursor_on, blink_on}, 3'b111);
    check("post-rst busy", busy, 1'b1);
    check("post-rst inc_mode", inc_mode, 1'b1);
    for (int i = 0; i < 16; i++) begin
      read_buf(4'(i), rb);
      check($sformatf("post-rst buf[%0d]", i), rb, 8'h20);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
